// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and helpers for the FIFO push arbiter.
// Arbiter state encoding, grant counter width, one-hot decode.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_HOLD
    } arb_state_e;

    localparam int GNT_CNT_W = 16;

    // Index of the set bit of a one-hot vector (up to 32 requesters).
    function automatic logic [4:0] onehot2idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Producer-side request bundle and FIFO push port of the arbiter.
// master: arbiter side; slave: producers/FIFO side.
interface fifo_push_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 1
);
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic                      fifo_full_i;
    logic                      fifo_push_o;
    logic [DATA_W-1:0]         fifo_push_data_o;
    logic                      busy_o;

    modport master (
        input  req_i,
        input  req_data_i,
        input  fifo_full_i,
        output gnt_o,
        output fifo_push_o,
        output fifo_push_data_o,
        output busy_o
    );

    modport slave (
        output req_i,
        output req_data_i,
        output fifo_full_i,
        input  gnt_o,
        input  fifo_push_o,
        input  fifo_push_data_o,
        input  busy_o
    );
endinterface

// File: rtl/fifo_push_arbiter_rr_prio_pick.sv
// Rotating-priority picker: first set req at or after ptr, wrapping.
// Ports: req, ptr in; one-hot gnt, binary idx, vld out.
module rr_prio_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      idx,
    output logic               vld
);
    logic [NUM_REQ-1:0] rot;
    logic [PW-1:0]      k;
    logic [PW:0]        sum;

    always_comb begin
        // Rotate so ptr lands on bit 0, find first set, rotate back.
        rot = NUM_REQ'({req, req} >> ptr);
        vld = |req;
        k   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) k = PW'(i);
        end
        sum = {1'b0, k} + {1'b0, ptr};
        if (sum >= (PW + 1)'(NUM_REQ)) sum = sum - (PW + 1)'(NUM_REQ);
        idx = sum[PW-1:0];
        gnt = '0;
        if (vld) gnt[idx] = 1'b1;
    end
endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ producers,
// with burst hold up to BURST_LEN pushes per grant.
// Ports: clk, reset (async active-low), bus (fifo_push_arbiter_if.master).
// Optional: ARB_GNT_CNT_EN adds gnt_cnt_o, saturating per-producer counters.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 1,
    parameter int BURST_LEN = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_push_arbiter_if.master   bus
`ifdef ARB_GNT_CNT_EN
    ,
    output logic [GNT_CNT_W-1:0]  gnt_cnt_o [NUM_REQ]
`endif
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);

    arb_state_e         state;
    logic [PW-1:0]      prio_ptr;
    logic [PW-1:0]      owner;
    logic [CW-1:0]      beat_cnt;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [PW-1:0]      pick_idx;
    logic               pick_vld;
    logic               hold_keep;
    logic [NUM_REQ-1:0] gnt;
    logic               push;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      ptr_next;

    rr_prio_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (bus.req_i),
        .ptr (prio_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // Owner keeps the port while it still requests; once it drops,
    // the picker arbitrates in the same cycle.
    assign hold_keep = (state == ARB_HOLD) && bus.req_i[owner];

    always_comb begin
        gnt = '0;
        if (!bus.fifo_full_i) begin
            if (hold_keep) gnt[owner] = 1'b1;
            else if (pick_vld) gnt = pick_gnt;
        end
        if (!reset) gnt = '0;
    end

    assign push    = |gnt;
    assign gnt_idx = PW'(onehot2idx(32'(gnt)));

    always_comb begin
        bus.fifo_push_data_o = '0;
        if (push) begin
            bus.fifo_push_data_o = bus.req_data_i[gnt_idx*DATA_W +: DATA_W];
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.fifo_push_o = push;
    assign bus.busy_o      = (state == ARB_HOLD) && reset;

    assign ptr_next = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + PW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB_IDLE;
            prio_ptr <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else if (hold_keep) begin
            // Full stalls the burst with count and owner frozen.
            if (!bus.fifo_full_i) begin
                if (beat_cnt == CW'(BURST_LEN - 1)) begin
                    state    <= ARB_IDLE;
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + CW'(1);
                end
            end
        end else if (push) begin
            owner    <= pick_idx;
            prio_ptr <= ptr_next;
            if (BURST_LEN > 1) begin
                state    <= ARB_HOLD;
                beat_cnt <= CW'(1);
            end else begin
                state    <= ARB_IDLE;
                beat_cnt <= '0;
            end
        end else begin
            state    <= ARB_IDLE;
            beat_cnt <= '0;
        end
    end

`ifdef ARB_GNT_CNT_EN
    logic [GNT_CNT_W-1:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + GNT_CNT_W'(1);
            end
        end
    end

    assign gnt_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: BURST_LEN=1 and BURST_LEN=2 instances
// driven in parallel; checks grant order, bursts, back-pressure and reset.
module tb_fifo_push_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] data;
    logic       full;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.NUM_REQ(4), .DATA_W(1)) b1 ();
    fifo_push_arbiter_if #(.NUM_REQ(4), .DATA_W(1)) b2 ();

    assign b1.req_i       = req;
    assign b1.req_data_i  = data;
    assign b1.fifo_full_i = full;
    assign b2.req_i       = req;
    assign b2.req_data_i  = data;
    assign b2.fifo_full_i = full;

`ifdef ARB_GNT_CNT_EN
    logic [15:0] cnt1 [4];
    logic [15:0] cnt2 [4];
`endif

    fifo_push_arbiter #(.NUM_REQ(4), .DATA_W(1), .BURST_LEN(1)) dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (b1.master)
`ifdef ARB_GNT_CNT_EN
        ,
        .gnt_cnt_o (cnt1)
`endif
    );

    fifo_push_arbiter #(.NUM_REQ(4), .DATA_W(1), .BURST_LEN(2)) dut2 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (b2.master)
`ifdef ARB_GNT_CNT_EN
        ,
        .gnt_cnt_o (cnt2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_rr   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_bg   [5] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001};
    logic       exp_busy [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       exp_dat  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        data  = 4'b0000;
        full  = 1'b0;
        #2;
        check("rst_gnt1",  32'(b1.gnt_o), 32'h0);
        check("rst_push1", 32'(b1.fifo_push_o), 32'h0);
        check("rst_busy1", 32'(b1.busy_o), 32'h0);
        check("rst_gnt2",  32'(b2.gnt_o), 32'h0);
        check("rst_push2", 32'(b2.fifo_push_o), 32'h0);
        check("rst_busy2", 32'(b2.busy_o), 32'h0);
`ifdef ARB_GNT_CNT_EN
        check("rst_cnt0", 32'(cnt2[0]), 32'h0);
`endif
        tick();
        rst_n = 1'b1;

        // Per-beat round robin
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                #1;
            end
            check($sformatf("rr_gnt%0d", i), 32'(b1.gnt_o), 32'(exp_rr[i]));
            check($sformatf("rr_push%0d", i), 32'(b1.fifo_push_o), 32'h1);
        end

        // Burst of two with data
        pulse_reset();
        req  = 4'b0101;
        data = 4'b0001;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                #1;
            end
            check($sformatf("bg_gnt%0d", i), 32'(b2.gnt_o), 32'(exp_bg[i]));
            check($sformatf("bg_busy%0d", i), 32'(b2.busy_o), 32'(exp_busy[i]));
            check($sformatf("bg_dat%0d", i), 32'(b2.fifo_push_data_o),
                  32'(exp_dat[i]));
        end

        // Back-pressure
        pulse_reset();
        req  = 4'b0100;
        data = 4'b0000;
        full = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                tick();
                #1;
            end
            check($sformatf("full_push%0d", i), 32'(b2.fifo_push_o), 32'h0);
            check($sformatf("full_gnt%0d", i), 32'(b2.gnt_o), 32'h0);
        end
        tick();
        full = 1'b0;
        #1;
        check("bp_first", 32'(b2.gnt_o), 32'h4);
        tick();
        full = 1'b1;
        #1;
        check("bp_stall_gnt",  32'(b2.gnt_o), 32'h0);
        check("bp_stall_busy", 32'(b2.busy_o), 32'h1);
        tick();
        full = 1'b0;
        #1;
        check("bp_resume_gnt",  32'(b2.gnt_o), 32'h4);
        check("bp_resume_busy", 32'(b2.busy_o), 32'h1);
        tick();
        #1;
        check("bp_new_gnt",  32'(b2.gnt_o), 32'h4);
        check("bp_new_busy", 32'(b2.busy_o), 32'h0);

        // Owner drops during hold
        pulse_reset();
        req = 4'b0001;
        #1;
        check("od_first", 32'(b2.gnt_o), 32'h1);
        tick();
        req = 4'b1000;
        #1;
        check("od_switch_gnt",  32'(b2.gnt_o), 32'h8);
        check("od_switch_busy", 32'(b2.busy_o), 32'h1);
        tick();
        #1;
        check("od_hold3_gnt",  32'(b2.gnt_o), 32'h8);
        check("od_hold3_busy", 32'(b2.busy_o), 32'h1);
        tick();
        #1;
        check("od_idle_busy", 32'(b2.busy_o), 32'h0);

        // Reset mid-burst
        pulse_reset();
        req = 4'b0100;
        #1;
        check("mr_first", 32'(b2.gnt_o), 32'h4);
        tick();
        #1;
        check("mr_busy", 32'(b2.busy_o), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mr_rst_gnt",  32'(b2.gnt_o), 32'h0);
        check("mr_rst_push", 32'(b2.fifo_push_o), 32'h0);
        check("mr_rst_busy", 32'(b2.busy_o), 32'h0);
`ifdef ARB_GNT_CNT_EN
        check("mr_rst_cnt2", 32'(cnt2[2]), 32'h0);
        check("mr_rst_cnt1", 32'(cnt2[1]), 32'h0);
`endif
        tick();
        rst_n = 1'b1;
        req   = 4'b1010;
        data  = 4'b0010;
        #1;
        check("mr_ptr0_gnt", 32'(b2.gnt_o), 32'h2);
        check("mr_ptr0_dat", 32'(b2.fifo_push_data_o), 32'h1);
        tick();
`ifdef ARB_GNT_CNT_EN
        check("mr_cnt1", 32'(cnt2[1]), 32'h1);
`endif
        check("mr_hold_busy", 32'(b2.busy_o), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
